// File: rtl/conway_pkg.sv
// conway_pkg: shared grid constants and encodings for the serial Life core and its sequencer
package conway_pkg;
  localparam int GRID_WIDTH = 8;
  localparam int GRID_HEIGHT = 8;
  localparam int DATA_SIZE = GRID_WIDTH * GRID_HEIGHT;
  typedef enum logic [1:0] {
    MODE_STOP = 2'b00,
    MODE_LOAD = 2'b01,
    MODE_RUN  = 2'b10,
    MODE_OUT  = 2'b11
  } core_mode_e;
  typedef enum logic [1:0] {
    CTRL_IDLE = 2'b00,
    CTRL_LOAD = 2'b01,
    CTRL_RUN  = 2'b10,
    CTRL_OUT  = 2'b11
  } ctrl_state_e;
endpackage

// File: rtl/terminal_counter.sv
// terminal_counter: up-counter with sync clear/enable; last flags the step that reaches limit
module terminal_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             last
);
  assign last = (count + 1'b1) == limit;
  always_ff @(posedge clk)
    if (rst || clr) count <= '0;
    else if (en) count <= count + 1'b1;
endmodule

// File: rtl/conway_run_controller.sv
// conway_run_controller: sequences load, a programmed number of generations and unload of the Life core
module conway_run_controller #(
  parameter int DATA_SIZE = 64,
  parameter int GEN_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [GEN_WIDTH-1:0] generations,
  input  logic                 load_valid,
  input  logic                 load_bit,
  output logic                 load_ready,
  output logic                 out_valid,
  output logic                 out_bit,
  input  logic                 out_ready,
  output logic [1:0]           core_mode,
  output logic                 core_data_in,
  input  logic                 core_data_out,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [GEN_WIDTH-1:0] gen_count
);
  import conway_pkg::*;
  localparam logic [1:0] IDLE = CTRL_IDLE;
  localparam logic [1:0] LOAD = CTRL_LOAD;
  localparam logic [1:0] RUN  = CTRL_RUN;
  localparam logic [1:0] OUT  = CTRL_OUT;
  localparam int BW = $clog2(DATA_SIZE + 1);
  localparam logic [BW-1:0] BIT_LIM = BW'(DATA_SIZE);
  logic [1:0] state, next_state;
  logic [GEN_WIDTH-1:0] gen_lim;
  logic [BW-1:0] bit_count;
  logic bit_last, gen_last;
  logic active, accept, reject, load_xfer, out_xfer, run_en;
  assign active    = state != IDLE;
  assign accept    = state == IDLE && start && generations != '0;
  assign reject    = state == IDLE && start && generations == '0;
  // abort suppresses every transfer in its cycle so the core never shifts on a cancelled job
  assign load_xfer = state == LOAD && load_valid && !abort;
  assign out_xfer  = state == OUT && out_ready && !abort;
  assign run_en    = state == RUN && !abort;
  assign load_ready   = state == LOAD && !abort;
  assign out_valid    = state == OUT && !abort;
  assign out_bit      = core_data_out;
  assign core_data_in = state == LOAD ? load_bit : 1'b0;
  assign busy         = active;
  always_comb begin
    core_mode  = load_xfer ? MODE_LOAD : run_en ? MODE_RUN : out_xfer ? MODE_OUT : MODE_STOP;
    next_state = (active && abort)         ? IDLE :
                 accept                    ? LOAD :
                 (load_xfer && bit_last)   ? RUN  :
                 (run_en && gen_last)      ? OUT  :
                 (out_xfer && bit_last)    ? IDLE : state;
  end
  always_ff @(posedge clk)
    if (reset) begin
      state   <= IDLE;
      gen_lim <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state <= next_state;
      if (accept) gen_lim <= generations;
      done <= out_xfer && bit_last;
      err  <= reject;
    end
  terminal_counter #(.WIDTH(BW)) u_bit_cnt (
    .clk   (clk),
    .rst   (reset),
    .clr   (accept || (load_xfer && bit_last)),
    .en    (load_xfer || out_xfer),
    .limit (BIT_LIM),
    .count (bit_count),
    .last  (bit_last)
  );
  terminal_counter #(.WIDTH(GEN_WIDTH)) u_gen_cnt (
    .clk   (clk),
    .rst   (reset),
    .clr   (accept),
    .en    (run_en),
    .limit (gen_lim),
    .count (gen_count),
    .last  (gen_last)
  );
  a_bit_range: assert property (@(posedge clk) disable iff (reset) bit_count <= BIT_LIM);
  a_gen_range: assert property (@(posedge clk) disable iff (reset) gen_count <= gen_lim);
endmodule

// File: tb/tb_conway_run_controller.sv
// tb_conway_run_controller: directed jobs against a behavioural Life core, scoreboarded unload
module tb_conway_run_controller;
  logic clk = 0, reset = 1, start = 0, abort = 0;
  logic [15:0] generations = '0;
  logic load_valid = 0, load_bit = 0, out_ready = 0;
  logic load_ready, out_valid, out_bit, core_data_in, core_data_out, busy, done, err;
  logic [1:0] core_mode;
  logic [15:0] gen_count;
  logic [63:0] mem = '0, oreg = '0;
  logic [63:0] glider, glider1, blink_h, blink_v;
  logic exp_q[$];
  int checks = 0, errors = 0;
  int c01 = 0, c11 = 0, streak = 0, max_run = 0, n_done = 0, gen_at_done = 0;

  conway_run_controller #(.DATA_SIZE(64), .GEN_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .generations(generations),
    .load_valid(load_valid), .load_bit(load_bit), .load_ready(load_ready),
    .out_valid(out_valid), .out_bit(out_bit), .out_ready(out_ready),
    .core_mode(core_mode), .core_data_in(core_data_in), .core_data_out(core_data_out),
    .busy(busy), .done(done), .err(err), .gen_count(gen_count)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] life(input logic [63:0] g);
    logic [63:0] n;
    n = '0;
    for (int i = 0; i < 64; i++) begin
      int r, c, k;
      r = i / 8; c = i % 8; k = 0;
      for (int dr = -1; dr <= 1; dr++)
        for (int dc = -1; dc <= 1; dc++)
          if ((dr != 0 || dc != 0) && r + dr >= 0 && r + dr < 8 && c + dc >= 0 && c + dc < 8)
            k += int'(g[(r + dr) * 8 + c + dc]);
      n[i] = (k == 3) || (g[i] && k == 2);
    end
    return n;
  endfunction

  // behavioural core: cell k is the k-th bit shifted in and the k-th bit shifted out
  always @(posedge clk)
    case (core_mode)
      2'b01: mem <= {core_data_in, mem[63:1]};
      2'b10: begin mem <= life(mem); oreg <= life(mem); end
      2'b11: oreg <= {1'b0, oreg[63:1]};
      default: ;
    endcase
  assign core_data_out = oreg[0];

  function automatic logic [63:0] mk(input int a, input int b, input int c, input int d, input int e);
    logic [63:0] g;
    g = '0;
    g[a] = 1'b1; g[b] = 1'b1; g[c] = 1'b1;
    if (d >= 0) g[d] = 1'b1;
    if (e >= 0) g[e] = 1'b1;
    return g;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (core_mode == 2'b01) c01++;
      if (core_mode == 2'b11) c11++;
      if (core_mode == 2'b10) begin
        streak++;
        if (streak > max_run) max_run = streak;
      end else streak = 0;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL out_extra: got bit %0b expected no transfer at %0t", out_bit, $time);
        end else chk("out_bit", 32'(out_bit), 32'(exp_q.pop_front()));
      end
      if (done) begin n_done++; gen_at_done = int'(gen_count); end
    end
  endtask

  task automatic clear_stats();
    c01 = 0; c11 = 0; streak = 0; max_run = 0; n_done = 0; gen_at_done = 0;
  endtask

  task automatic push_exp(input logic [63:0] g);
    for (int i = 0; i < 64; i++) exp_q.push_back(g[i]);
  endtask

  task automatic start_job(input logic [15:0] g);
    start = 1; generations = g;
    @(posedge clk); #1 start = 0;
    @(negedge clk); chk("ready_after_start", 32'(load_ready), 1);
    @(posedge clk); #1;
  endtask

  task automatic load_grid(input logic [63:0] pat, input int nbits, input bit rnd);
    int idx, guard;
    logic xfer;
    idx = 0; guard = 0;
    while (idx < nbits && guard < 2000) begin
      load_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      load_bit = pat[idx];
      @(negedge clk); xfer = load_valid && load_ready;
      @(posedge clk); #1;
      if (xfer) idx++;
      guard++;
    end
    load_valid = 0; load_bit = 0;
    if (guard >= 2000) chk("load_timeout", 1, 0);
  endtask

  task automatic unload(input bit rnd, input bit hold_start, input bit poke_run);
    int guard;
    bit got;
    guard = 0; got = 0;
    while (!got && guard < 3000) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      start = hold_start || (poke_run && core_mode == 2'b10);
      @(negedge clk); if (done) got = 1;
      @(posedge clk); #1;
      guard++;
    end
    out_ready = 0;
    if (!hold_start) start = 0;
    chk("done_seen", 32'(got), 1);
  endtask

  initial begin
    glider  = mk(1, 10, 16, 17, 18);
    glider1 = mk(8, 10, 17, 18, 25);
    blink_h = mk(26, 27, 28, -1, -1);
    blink_v = mk(19, 27, 35, -1, -1);
    fork monitor(); join_none
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_mode", 32'(core_mode), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ready", 32'(load_ready), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_gen", 32'(gen_count), 0);
    chk("rst_din", 32'(core_data_in), 0);
    chk("rst_done_err", {30'd0, done, err}, 0);
    @(posedge clk); #1 reset = 0;

    // reset asserted while the core is running
    clear_stats();
    start_job(16'd5);
    load_grid(glider, 64, 0);
    @(negedge clk); chk("in_run_mode", 32'(core_mode), 2);
    @(posedge clk); #1 reset = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("midrun_rst_mode", 32'(core_mode), 0);
    chk("midrun_rst_busy", 32'(busy), 0);
    chk("midrun_rst_gen", 32'(gen_count), 0);
    @(posedge clk); #1 reset = 0;
    repeat (2) @(posedge clk); #1;
    chk("midrun_no_done", 32'(n_done), 0);

    // glider, one generation, no backpressure
    clear_stats();
    push_exp(glider1);
    start_job(16'd1);
    load_grid(glider, 64, 0);
    unload(0, 0, 0);
    chk("g1_load_cycles", 32'(c01), 64);
    chk("g1_run_cycles", 32'(max_run), 1);
    chk("g1_out_cycles", 32'(c11), 64);
    chk("g1_done_count", 32'(n_done), 1);
    chk("g1_gen_at_done", 32'(gen_at_done), 1);
    chk("g1_queue_empty", 32'(exp_q.size()), 0);

    // blinker, five generations, random backpressure, start poked during RUN
    clear_stats();
    push_exp(blink_v);
    start_job(16'd5);
    load_grid(blink_h, 64, 1);
    unload(1, 0, 1);
    chk("g5_load_cycles", 32'(c01), 64);
    chk("g5_run_cycles", 32'(max_run), 5);
    chk("g5_out_cycles", 32'(c11), 64);
    chk("g5_done_count", 32'(n_done), 1);
    chk("g5_gen_at_done", 32'(gen_at_done), 5);
    chk("g5_queue_empty", 32'(exp_q.size()), 0);

    // zero-generation request is rejected
    start = 1; generations = 16'd0;
    @(posedge clk); #1 start = 0;
    @(negedge clk);
    chk("zero_err", 32'(err), 1);
    chk("zero_busy", 32'(busy), 0);
    chk("zero_mode", 32'(core_mode), 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("zero_err_once", 32'(err), 0);
    chk("zero_still_idle", 32'(busy), 0);
    @(posedge clk); #1;

    // abort after 30 load transfers, then a clean blinker job
    clear_stats();
    start_job(16'd3);
    load_grid(glider, 30, 0);
    abort = 1; load_valid = 1;
    @(negedge clk); chk("abort_mode", 32'(core_mode), 0);
    @(posedge clk); #1 abort = 0; load_valid = 0;
    @(negedge clk);
    chk("abort_idle", 32'(busy), 0);
    chk("abort_no_done", 32'(done), 0);
    chk("abort_ready_low", 32'(load_ready), 0);
    @(posedge clk); #1;
    push_exp(blink_h);
    start_job(16'd2);
    load_grid(blink_h, 64, 0);
    unload(0, 0, 0);
    chk("blink2_done_count", 32'(n_done), 1);
    chk("blink2_gen_at_done", 32'(gen_at_done), 2);
    chk("blink2_queue_empty", 32'(exp_q.size()), 0);

    // start held through done launches the next job immediately
    clear_stats();
    push_exp(glider1);
    start_job(16'd1);
    load_grid(glider, 64, 0);
    unload(0, 1, 0);
    start = 0;
    @(negedge clk);
    chk("back2back_ready", 32'(load_ready), 1);
    chk("back2back_busy", 32'(busy), 1);
    @(posedge clk); #1;
    push_exp(blink_v);
    load_grid(blink_h, 64, 0);
    unload(0, 0, 0);
    chk("back2back_done_count", 32'(n_done), 2);
    chk("back2back_queue_empty", 32'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
